// File: rtl/music_pkg.sv
// Shared constants for the PS/2 piano-key front end: the pitch-to-phase ROM,
// scancodes, the key-to-semitone map and the decoder state encoding.
package music_pkg;

  // Phase increment for MIDI note 36+p at 48 kHz with a 24-bit accumulator.
  localparam logic [23:0] FREQ_LUT [0:63] = '{
    24'd22861,  24'd24221,  24'd25661,  24'd27187,  24'd28803,  24'd30516,
    24'd32331,  24'd34253,  24'd36290,  24'd38448,  24'd40734,  24'd43156,
    24'd45722,  24'd48441,  24'd51322,  24'd54373,  24'd57607,  24'd61032,
    24'd64661,  24'd68506,  24'd72580,  24'd76896,  24'd81468,  24'd86312,
    24'd91445,  24'd96882,  24'd102643, 24'd108747, 24'd115213, 24'd122064,
    24'd129322, 24'd137012, 24'd145160, 24'd153791, 24'd162936, 24'd172625,
    24'd182890, 24'd193765, 24'd205287, 24'd217494, 24'd230426, 24'd244128,
    24'd258645, 24'd274025, 24'd290319, 24'd307582, 24'd325872, 24'd345249,
    24'd365779, 24'd387529, 24'd410573, 24'd434987, 24'd460853, 24'd488256,
    24'd517290, 24'd548049, 24'd580638, 24'd615165, 24'd651744, 24'd690499,
    24'd731558, 24'd775059, 24'd821146, 24'd869974
  };

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_OCT_DN = 8'h4E;
  localparam logic [7:0] SC_OCT_UP = 8'h55;

  localparam int unsigned NUM_KEYS   = 13;
  localparam logic [2:0]  OCTAVE_MAX = 3'd4;
  localparam logic [2:0]  OCTAVE_RST = 3'd2;

  typedef logic [1:0] dec_state_t;
  localparam dec_state_t ST_IDLE    = 2'd0;
  localparam dec_state_t ST_BRK     = 2'd1;
  localparam dec_state_t ST_EXT     = 2'd2;
  localparam dec_state_t ST_EXT_BRK = 2'd3;

  typedef struct packed {
    logic       hit;
    logic [3:0] semitone;
  } key_map_t;

  function automatic key_map_t key_lookup(input logic [7:0] code);
    key_map_t m;
    m.hit      = 1'b1;
    m.semitone = 4'd0;
    case (code)
      8'h1A:   m.semitone = 4'd0;
      8'h1B:   m.semitone = 4'd1;
      8'h22:   m.semitone = 4'd2;
      8'h23:   m.semitone = 4'd3;
      8'h21:   m.semitone = 4'd4;
      8'h2A:   m.semitone = 4'd5;
      8'h34:   m.semitone = 4'd6;
      8'h32:   m.semitone = 4'd7;
      8'h33:   m.semitone = 4'd8;
      8'h31:   m.semitone = 4'd9;
      8'h3B:   m.semitone = 4'd10;
      8'h3A:   m.semitone = 4'd11;
      8'h41:   m.semitone = 4'd12;
      default: m.hit      = 1'b0;
    endcase
    return m;
  endfunction

  function automatic logic [5:0] note_pitch(input logic [2:0] oct, input logic [3:0] semitone);
    return 6'(oct) * 6'd12 + 6'(semitone);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver: synchronises the raw lines, shifts in
// one 11-bit frame per byte and reports either a good byte or a framing error.
module ps2_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_o,
  output logic       frame_err_o
);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]      clk_sync_q, data_sync_q;
  logic            clk_prev_q;
  logic            fall, bit_in;
  logic [3:0]      bit_cnt_q, bit_cnt_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            start_ok_q, start_ok_d;
  logic            par_q, par_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [7:0]      byte_q;

  // Lines idle high, so the synchronisers reset high to avoid a false edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk_i};
      data_sync_q <= {data_sync_q[0], ps2_data_i};
      clk_prev_q  <= clk_sync_q[1];
    end
  end

  assign fall   = clk_prev_q & ~clk_sync_q[1];
  assign bit_in = data_sync_q[1];

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    bit_cnt_d  = bit_cnt_q;
    to_cnt_d   = to_cnt_q;
    shift_d    = shift_q;
    start_ok_d = start_ok_q;
    par_d      = par_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if (fall) begin
      to_cnt_d = '0;
      case (bit_cnt_q)
        4'd0: begin
          start_ok_d = ~bit_in;
          bit_cnt_d  = 4'd1;
        end
        4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8: begin
          shift_d   = {bit_in, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
        4'd9: begin
          par_d     = bit_in;
          bit_cnt_d = 4'd10;
        end
        4'd10: begin
          bit_cnt_d = 4'd0;
          if (start_ok_q && (^{shift_q, par_q}) && bit_in) valid_d = 1'b1;
          else                                            err_d   = 1'b1;
        end
        default: bit_cnt_d = 4'd0;
      endcase
    end else if (bit_cnt_q != 4'd0) begin
      // A stalled partial frame is dropped without reporting an error.
      if (to_cnt_q == TO_LAST) begin
        bit_cnt_d = 4'd0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + TO_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q  <= 4'd0;
      to_cnt_q   <= '0;
      shift_q    <= 8'd0;
      start_ok_q <= 1'b0;
      par_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      byte_q     <= 8'd0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      to_cnt_q   <= to_cnt_d;
      shift_q    <= shift_d;
      start_ok_q <= start_ok_d;
      par_q      <= par_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      if (valid_d) byte_q <= shift_q;
    end
  end

  assign byte_valid_o = valid_q;
  assign byte_o       = byte_q;
  assign frame_err_o  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard to piano-key events: make/break decoding with typematic
// suppression, octave shift and a registered pitch-to-phase ROM read.
module ps2_key_decoder
  import music_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic        key_press,
  output logic        key_release,
  output logic [5:0]  pitch,
  output logic [23:0] freq,
  output logic [2:0]  octave,
  output logic        frame_err
);
  logic       rx_valid, rx_err;
  logic [7:0] rx_byte;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk          (clk),
    .rst          (rst),
    .ps2_clk_i    (ps2_clk),
    .ps2_data_i   (ps2_data),
    .byte_valid_o (rx_valid),
    .byte_o       (rx_byte),
    .frame_err_o  (rx_err)
  );

  dec_state_t          state_q, state_d;
  logic [NUM_KEYS-1:0] held_q, held_d;
  logic [2:0]          octave_q, octave_d;
  logic [5:0]          pitch_q, pitch_d;
  logic [23:0]         freq_q;
  logic                press_q, press_d, release_q, release_d;
  logic [5:0]          key_pitch_q [NUM_KEYS];
  logic                kp_we;
  logic [5:0]          kp_val;
  key_map_t            km;

  assign km     = key_lookup(rx_byte);
  assign kp_val = note_pitch(octave_q, km.semitone);

  always_comb begin
    state_d   = state_q;
    held_d    = held_q;
    octave_d  = octave_q;
    pitch_d   = pitch_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    kp_we     = 1'b0;
    if (rx_err) begin
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_byte == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (rx_byte == SC_EXT) begin
            state_d = ST_EXT;
          end else if (rx_byte == SC_OCT_DN) begin
            if (octave_q != 3'd0) octave_d = octave_q - 3'd1;
          end else if (rx_byte == SC_OCT_UP) begin
            if (octave_q != OCTAVE_MAX) octave_d = octave_q + 3'd1;
          end else if (km.hit && !held_q[km.semitone]) begin
            held_d[km.semitone] = 1'b1;
            kp_we               = 1'b1;
            press_d             = 1'b1;
            pitch_d             = kp_val;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          // Release with the pitch captured at press time, not the current octave.
          if (km.hit && held_q[km.semitone]) begin
            held_d[km.semitone] = 1'b0;
            release_d           = 1'b1;
            pitch_d             = key_pitch_q[km.semitone];
          end
        end
        ST_EXT:  state_d = (rx_byte == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      held_q    <= '0;
      octave_q  <= OCTAVE_RST;
      pitch_q   <= 6'd0;
      freq_q    <= 24'd0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      held_q    <= held_d;
      octave_q  <= octave_d;
      press_q   <= press_d;
      release_q <= release_d;
      if (press_d || release_d) begin
        pitch_q <= pitch_d;
        freq_q  <= FREQ_LUT[pitch_d];
      end
    end
  end

  // NOTE: the per-key pitch store has no reset; an entry is only read while its held bit is set.
  always_ff @(posedge clk) begin
    if (kp_we) key_pitch_q[km.semitone] <= kp_val;
  end

  assign key_press   = press_q;
  assign key_release = release_q;
  assign pitch       = pitch_q;
  assign freq        = freq_q;
  assign octave      = octave_q;
  assign frame_err   = rx_err;

endmodule
